mul_wb_scheduler: RTL and testbench

- Issue-side scheduler that shares the single EXE writeback port between the ALU, the 2-stage multiplier and the iterative divider.
- The multiplier returns 32-bit (MULW/op_32) results 1 cycle after issue and 64-bit results 2 cycles after issue. Without scheduling, a MUL64 followed by a MUL32 or ALU op collides at writeback.
- The block keeps a writeback-slot reservation table, gates issue on conflicts, grants the divider free slots and prevents divider starvation.

---
 rtl/drac_pkg.sv | 20 ++
 rtl/wb_slot_shreg.sv | 40 ++++
 rtl/mul_wb_scheduler.sv | 98 +++++++++
 tb/tb_mul_wb_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// Shared EXE-stage definitions: writeback owners and unit latencies, so the
// execution pipes and the writeback scheduler always agree on timing.
package drac_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MUL  = 2'd2,
        WB_DIV  = 2'd3
    } wb_owner_t;

    localparam int ALU_LAT        = 1;
    localparam int MUL32_LAT      = 1;
    localparam int MUL64_LAT      = 2;
    localparam int MAX_LAT        = MUL64_LAT;
    localparam int WB_SLOTS       = MAX_LAT + 1;
    localparam int SLOT_IDX_W     = $clog2(WB_SLOTS);
    localparam int DIV_STARVE_DEF = 4;

endpackage

// File: rtl/wb_slot_shreg.sv
// Writeback reservation table: entry k names the owner k cycles from now.
// Shifts toward entry 0 every cycle; one owner may be inserted after the shift.
module wb_slot_shreg
    import drac_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  ins_en_i,
    input  logic [SLOT_IDX_W-1:0] ins_idx_i,
    input  wb_owner_t             ins_owner_i,
    output wb_owner_t             own_o [WB_SLOTS]
);

    for (genvar gi = 0; gi < WB_SLOTS; gi++) begin : g_slot
        wb_owner_t slot_reg;
        wb_owner_t slot_next;

        if (gi == WB_SLOTS - 1) begin : g_top
            assign slot_next = WB_NONE;
        end else begin : g_mid
            assign slot_next = own_o[gi+1];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                slot_reg <= WB_NONE;
            end else if (clear_i) begin
                slot_reg <= WB_NONE;
            end else if (ins_en_i && (ins_idx_i == SLOT_IDX_W'(gi))) begin
                slot_reg <= ins_owner_i;
            end else begin
                slot_reg <= slot_next;
            end
        end

        assign own_o[gi] = slot_reg;
    end

endmodule

// File: rtl/mul_wb_scheduler.sv
// Shares the EXE writeback port between ALU, multiplier and divider: reserves
// fixed-latency slots at issue, fills idle slots with the divider, bounds its wait.
module mul_wb_scheduler
    import drac_pkg::*;
#(
    parameter int DIV_STARVE = DIV_STARVE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kill_i,
    input  logic       issue_valid_i,
    input  logic [1:0] issue_unit_i,
    input  logic       issue_op32_i,
    output logic       issue_ready_o,
    input  logic       div_done_i,
    output logic       div_grant_o,
    output logic [1:0] wb_sel_o,
    output logic       wb_valid_o,
    output logic       div_inflight_o
);

    localparam int STARVE_W = $clog2(DIV_STARVE + 1);

    wb_owner_t             own_q [WB_SLOTS];
    wb_owner_t             issue_unit;
    logic [SLOT_IDX_W-1:0] lat;
    logic                  unit_ok;
    logic                  fixed_lat;
    logic                  block;
    logic                  accept;
    logic                  div_inflight_q;
    logic [STARVE_W-1:0]   starve_cnt_q;

    assign issue_unit = wb_owner_t'(issue_unit_i);
    assign fixed_lat  = (issue_unit == WB_ALU) || (issue_unit == WB_MUL);
    assign block      = (starve_cnt_q >= STARVE_W'(DIV_STARVE));

    always_comb begin
        lat     = '0;
        unit_ok = 1'b1;
        case (issue_unit)
            WB_ALU: begin
                lat     = SLOT_IDX_W'(ALU_LAT);
                unit_ok = (own_q[lat] == WB_NONE) && !block;
            end
            WB_MUL: begin
                lat     = issue_op32_i ? SLOT_IDX_W'(MUL32_LAT) : SLOT_IDX_W'(MUL64_LAT);
                unit_ok = (own_q[lat] == WB_NONE) && !block;
            end
            WB_DIV:  unit_ok = !div_inflight_q;
            default: unit_ok = 1'b1;
        endcase
    end

    assign issue_ready_o = !kill_i && unit_ok;
    assign accept        = issue_valid_i && issue_ready_o;

    // The divider only ever fills a slot nobody reserved.
    assign div_grant_o = div_done_i && div_inflight_q && (own_q[0] == WB_NONE);
    assign wb_sel_o    = (own_q[0] != WB_NONE) ? own_q[0] :
                         (div_grant_o ? WB_DIV : WB_NONE);
    assign wb_valid_o     = (wb_sel_o != WB_NONE);
    assign div_inflight_o = div_inflight_q;

    wb_slot_shreg u_slots (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (kill_i),
        .ins_en_i    (accept && fixed_lat),
        .ins_idx_i   (lat - SLOT_IDX_W'(1)),
        .ins_owner_i (issue_unit),
        .own_o       (own_q)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_inflight_q <= 1'b0;
        end else if (kill_i) begin
            div_inflight_q <= 1'b0;
        end else if (accept && (issue_unit == WB_DIV)) begin
            div_inflight_q <= 1'b1;
        end else if (div_grant_o) begin
            div_inflight_q <= 1'b0;
        end
    end

    // Counts cycles a finished divide has been denied; saturates at DIV_STARVE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else if (kill_i || div_grant_o || !div_done_i) begin
            starve_cnt_q <= '0;
        end else if (!block) begin
            starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
        end
    end

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Directed plus random checking of mul_wb_scheduler against a cycle-indexed
// writeback calendar model.
module tb_mul_wb_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       kill_i = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic [1:0] issue_unit_i = 2'd0;
    logic       issue_op32_i = 1'b0;
    logic       issue_ready_o;
    logic       div_done_i = 1'b0;
    logic       div_grant_o;
    logic [1:0] wb_sel_o;
    logic       wb_valid_o;
    logic       div_inflight_o;

    int total = 0;
    int bad   = 0;

    // Model: absolute cycle number -> unit that owns writeback in that cycle.
    int owner_at [int];
    int cyc = 0;
    bit m_inflight = 0;
    int m_wait = 0;

    always #5 clk_i = ~clk_i;

    mul_wb_scheduler dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .kill_i         (kill_i),
        .issue_valid_i  (issue_valid_i),
        .issue_unit_i   (issue_unit_i),
        .issue_op32_i   (issue_op32_i),
        .issue_ready_o  (issue_ready_o),
        .div_done_i     (div_done_i),
        .div_grant_o    (div_grant_o),
        .wb_sel_o       (wb_sel_o),
        .wb_valid_o     (wb_valid_o),
        .div_inflight_o (div_inflight_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic int owner_of(input int c);
        return owner_at.exists(c) ? owner_at[c] : 0;
    endfunction

    // One clock of stimulus; called at posedge+1, checks at posedge+4.
    task automatic step(input bit v, input int unit, input bit op32, input bit kill,
                        input bit done, input int want_ready);
        int  lat;
        int  cur;
        bit  e_ready;
        bit  e_grant;
        int  e_sel;
        issue_valid_i = v;
        issue_unit_i  = unit[1:0];
        issue_op32_i  = op32;
        kill_i        = kill;
        div_done_i    = done;
        #3;
        lat = (unit == 1) ? 1 : (op32 ? 1 : 2);
        cur = owner_of(cyc);
        if (kill)                       e_ready = 0;
        else if (unit == 0)             e_ready = 1;
        else if (unit == 3)             e_ready = !m_inflight;
        else                            e_ready = (owner_of(cyc + lat) == 0) && (m_wait < 4);
        e_grant = done && m_inflight && (cur == 0);
        e_sel   = (cur != 0) ? cur : (e_grant ? 3 : 0);
        chk("issue_ready", 32'(issue_ready_o), 32'(e_ready));
        chk("div_grant", 32'(div_grant_o), 32'(e_grant));
        chk("wb_sel", 32'(wb_sel_o), 32'(e_sel));
        chk("wb_valid", 32'(wb_valid_o), 32'(e_sel != 0));
        chk("div_inflight", 32'(div_inflight_o), 32'(m_inflight));
        if (want_ready >= 0) chk("directed_ready", 32'(issue_ready_o), 32'(want_ready));
        $display("cyc=%0d v=%0d unit=%0d op32=%0d kill=%0d done=%0d ready=%0d sel=%0d grant=%0d",
                 cyc, v, unit, op32, kill, done, issue_ready_o, wb_sel_o, div_grant_o);
        @(posedge clk_i);
        if (kill) begin
            for (int k = 1; k <= 4; k++) owner_at.delete(cyc + k);
            m_inflight = 0;
            m_wait     = 0;
        end else begin
            if (v && e_ready && (unit == 1 || unit == 2)) owner_at[cyc + lat] = unit;
            if (v && e_ready && unit == 3)  m_inflight = 1;
            else if (e_grant)               m_inflight = 0;
            if (e_grant || !done)           m_wait = 0;
            else if (m_wait < 4)            m_wait++;
        end
        owner_at.delete(cyc);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        div_done_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("rst_wb_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_div_grant", 32'(div_grant_o), 32'd0);
        chk("rst_div_inflight", 32'(div_inflight_o), 32'd0);
        $display("cyc=%0d reset asserted", cyc);
        owner_at.delete();
        m_inflight = 0;
        m_wait     = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc++;
    endtask

    initial begin
        #2;
        chk("init_wb_sel", 32'(wb_sel_o), 32'd0);
        chk("init_div_inflight", 32'(div_inflight_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cyc = 1;

        step(1, 1, 0, 0, 0, 1);          // ALU ready after reset
        step(0, 0, 0, 0, 0, -1);
        // MUL64 then ALU: collision stall, then accepted
        step(1, 2, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, -1);
        // MUL64 then MUL32 stalls
        step(1, 2, 0, 0, 0, 1);
        step(1, 2, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, -1);
        // back-to-back MUL32 and MUL64
        step(1, 2, 1, 0, 0, 1);
        step(1, 2, 1, 0, 0, 1);
        step(1, 2, 0, 0, 0, 1);
        step(1, 2, 0, 0, 0, 1);
        step(1, 2, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, -1);
        step(0, 0, 0, 0, 0, -1);
        // DIV serialization
        step(1, 3, 0, 0, 0, 1);
        step(1, 3, 0, 0, 0, 0);
        step(1, 3, 0, 0, 1, 0);          // grant this cycle
        step(1, 3, 0, 0, 0, 1);
        // starvation: ALU every cycle holds slot 0 while divider waits
        step(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);          // slot 0 free: grant
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, -1);
        // kill after MUL64 with a divide in flight
        step(1, 3, 0, 0, 0, 1);
        step(1, 2, 0, 0, 0, 1);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, -1);
        // reset mid-traffic
        step(1, 3, 0, 0, 0, 1);
        step(1, 2, 0, 0, 0, 1);
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, -1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 1) == 1, -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
